// File: rtl/crc8_rx_chk_if.sv
// Receive-side byte stream in, payload stream and frame check status out.
// Purely a bundle of wires; no latency of its own.
// No backpressure: the receive side is a valid-only stream.
interface crc8_rx_chk_if;
  logic [7:0]  rx_din;
  logic        rx_vld;
  logic        rx_sop;
  logic        rx_eop;
  logic [7:0]  out_dout;
  logic        out_vld;
  logic        out_sop;
  logic        out_eop;
  logic        chk_done;
  logic        chk_err;
  logic [10:0] frm_len;
  logic [15:0] err_cnt;

  // Source of the received byte stream; consumer of the results.
  modport master (
    output rx_din, rx_vld, rx_sop, rx_eop,
    input  out_dout, out_vld, out_sop, out_eop, chk_done, chk_err, frm_len, err_cnt
  );

  // The checker itself.
  modport slave (
    input  rx_din, rx_vld, rx_sop, rx_eop,
    output out_dout, out_vld, out_sop, out_eop, chk_done, chk_err, frm_len, err_cnt
  );
endinterface

// File: rtl/crc8_rx_chk.sv
// CRC-8 (poly 0x07, init 0xFF) frame checker; strips the trailing CRC byte from the payload.
// Latency: 1 cycle from an accepted byte to emission of the previously held byte; status 1 cycle after eop.
// No backpressure: every valid beat is consumed. Optional macro CRC_ERR_CNT_EN enables the error counter.
module crc8_rx_chk (
  input  logic         clk_sys,
  input  logic         rst_sys,
  crc8_rx_chk_if.slave bus
);

  typedef enum logic {IDLE, RECV} state_t;

  state_t      state_q, state_d;
  logic [7:0]  crc_q, crc_d;
  logic [7:0]  hold_q, hold_d;
  logic        first_q, first_d;
  logic [10:0] cnt_q, cnt_d;
  logic [10:0] len_q, len_d;
  logic [7:0]  dout_q, dout_d;
  logic        vld_q, vld_d;
  logic        sop_q, sop_d;
  logic        eop_q, eop_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [7:0]  crc_seed;
  logic [7:0]  crc_next;

  // Fold one byte into the CRC, MSB first, no reflection.
  function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) begin
      r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
    end
    return r;
  endfunction

  // Payload counts stick at the 11-bit maximum instead of wrapping.
  function automatic logic [10:0] sat_inc(input logic [10:0] v);
    return (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

  // Next-state: framing, CRC update, hold register and one-cycle output strobes.
  always_comb begin
    state_d  = state_q;
    crc_d    = crc_q;
    hold_d   = hold_q;
    first_d  = first_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    dout_d   = 8'h00;
    vld_d    = 1'b0;
    sop_d    = 1'b0;
    eop_d    = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    // A sop always restarts the CRC, even when it aborts a frame in progress.
    crc_seed = bus.rx_sop ? 8'hFF : crc_q;
    crc_next = crc8_byte(crc_seed, bus.rx_din);

    if (bus.rx_vld) begin
      if (bus.rx_sop) begin
        // New frame; any held byte of an aborted frame is silently dropped.
        crc_d   = crc_next;
        hold_d  = bus.rx_din;
        cnt_d   = 11'd0;
        first_d = 1'b1;
        if (bus.rx_eop) begin
          // A lone byte is only a CRC with no payload: flag as short.
          done_d  = 1'b1;
          err_d   = 1'b1;
          len_d   = 11'd0;
          state_d = IDLE;
        end else begin
          state_d = RECV;
        end
      end else if (state_q == RECV) begin
        vld_d   = 1'b1;
        dout_d  = hold_q;
        sop_d   = first_q;
        first_d = 1'b0;
        crc_d   = crc_next;
        if (bus.rx_eop) begin
          // This beat is the CRC byte: it is checked but never emitted.
          eop_d   = 1'b1;
          done_d  = 1'b1;
          err_d   = (crc_next != 8'h00);
          len_d   = sat_inc(cnt_q);
          state_d = IDLE;
        end else begin
          hold_d = bus.rx_din;
          cnt_d  = sat_inc(cnt_q);
        end
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk_sys or negedge rst_sys) begin
    if (!rst_sys) begin
      state_q <= IDLE;
      crc_q   <= 8'hFF;
      hold_q  <= 8'h00;
      first_q <= 1'b0;
      cnt_q   <= 11'd0;
      len_q   <= 11'd0;
      dout_q  <= 8'h00;
      vld_q   <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      hold_q  <= hold_d;
      first_q <= first_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.out_dout = dout_q;
  assign bus.out_vld  = vld_q;
  assign bus.out_sop  = sop_q;
  assign bus.out_eop  = eop_q;
  assign bus.chk_done = done_q;
  assign bus.chk_err  = err_q;
  assign bus.frm_len  = len_q;

`ifdef CRC_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  // Count failed frames, sticking at the maximum; updates alongside chk_done.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (done_d && err_d && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  // Error counter register.
  always_ff @(posedge clk_sys or negedge rst_sys) begin
    if (!rst_sys) begin
      err_cnt_q <= 16'h0000;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.err_cnt = err_cnt_q;
`else
  assign bus.err_cnt = 16'h0000;
`endif

endmodule

// File: doc/crc8_rx_chk.md
CRC8_RX_CHK -- requirements
Module: crc8_rx_chk

Interface
REQ-001 The block SHALL use a single clock; reset is asynchronous and active-low.
REQ-002 clk_sys  input  1  system clock; all flops rise-edge triggered.
REQ-003 rst_sys  input  1  asynchronous active-low reset.
REQ-004 rx_din  input  8  received byte; the last byte of each frame is the CRC byte.
REQ-005 rx_vld  input  1  rx_din valid this cycle; rx_sop and rx_eop are qualified by rx_vld.
REQ-006 rx_sop  input  1  first byte of frame.
REQ-007 rx_eop  input  1  last byte of frame (the CRC byte).
REQ-008 out_dout  output  8  payload byte with the CRC byte stripped.
REQ-009 out_vld, out_sop, out_eop  output  1 each  payload stream strobes.
REQ-010 chk_done  output  1  one-cycle pulse when a frame's check completes.
REQ-011 chk_err  output  1  valid only with chk_done; 1 means CRC mismatch or a short frame.
REQ-012 frm_len  output  11  payload byte count of the last checked frame; held until the next chk_done.
REQ-013 err_cnt  output  16  count of frames with chk_err=1.

Function
REQ-014 CRC SHALL be CRC-8 with polynomial x^8+x^2+x+1 (0x07), init 0xFF, MSB-first, no reflection, no final XOR, one byte per accepted beat.
REQ-015 A frame SHALL pass when the CRC register equals 0x00 after all bytes, including the CRC byte, have been folded in.
REQ-016 FSM states: IDLE and RECV; IDLE goes to RECV on rx_vld&rx_sop&!rx_eop; RECV goes to IDLE on rx_vld&rx_eop.
REQ-017 In IDLE, beats without rx_sop SHALL be ignored: no CRC update, no output.
REQ-018 On rx_sop, the CRC SHALL be seeded with 0xFF before the sop byte is folded in, so the sop byte uses init 0xFF.
REQ-019 A one-byte hold register SHALL store each accepted byte; each new accepted byte emits the previously held byte on out_* in the following cycle (1-cycle registered latency).
REQ-020 out_sop SHALL be set on the first emitted byte of a frame, which is emitted when the frame's second byte arrives.
REQ-021 On an rx_eop beat in cycle t, at t+1 the block SHALL emit the held byte with out_eop=1, pulse chk_done with chk_err, update frm_len, and drop the CRC byte.
REQ-022 rx_sop&rx_eop on the same beat (1-byte frame) SHALL give: no out_vld, chk_done=1, chk_err=1, frm_len=0.
REQ-023 rx_sop while in RECV SHALL abort the current frame: held byte discarded, no out_eop, no chk_done; the CRC reseeds and the new frame starts.
REQ-024 frm_len SHALL saturate at 2047.
REQ-025 Outside the cases in REQ-019 to REQ-022, out_vld, out_sop, out_eop and chk_done SHALL be 0.

Reset
REQ-026 While rst_sys=0: FSM=IDLE, CRC register=0xFF, hold register=0x00, all out_* and chk_* outputs =0, frm_len=0, err_cnt=0.
REQ-027 Reset asserted mid-frame SHALL discard the frame with no chk_done pulse after release.

Configuration
REQ-028 Macro CRC_ERR_CNT_EN defined: err_cnt SHALL increment by 1 on each chk_done with chk_err=1 and saturate at 0xFFFF.
REQ-029 Macro CRC_ERR_CNT_EN undefined: err_cnt SHALL be tied to 0 and the counter logic omitted.

Verification
REQ-030 Frame {0x00,0xF3} -> out: 0x00 with sop=eop=1; chk_done=1, chk_err=0, frm_len=1.
REQ-031 Frame {0x00,0xF2} -> chk_err=1; err_cnt=1 with CRC_ERR_CNT_EN defined, 0 without.
REQ-032 Frame {0xFF,0x00} -> pass, frm_len=1; a single-beat sop+eop frame 0x5A -> chk_err=1, frm_len=0, no out_vld.
REQ-033 Frame {0x11,0x22} interrupted by sop of frame {0x00,0xF3} -> no chk_done for the first frame; the second frame passes.
REQ-034 Beats with rx_vld=0 gaps between frame bytes -> same results as back-to-back; stray IDLE beats without sop -> no output.
REQ-035 rst_sys pulsed low after 2 of 3 bytes -> all outputs 0, no chk_done; the next valid frame passes.
